frame_buffer_scheduler: RTL and testbench
=========================================

Name: frame_buffer_scheduler

Overview:
- Triple-buffer scheduler for the DDR frame store in the 100 MHz AXI domain.
- Owns three frame slots at FRAME_BASE_ADDR + idx*FRAME_STRIDE.
- Gives the stream-to-DDR writer its next slot at every frame boundary, without ever switching in the middle of a burst.
- Gives the HDMI reader the most recently completed frame at each of its frame starts.
- Guarantees the writer and reader never use the same slot at the same time.

Parameters:
- AXI_ADDR_WIDTH, 32, width of the base-address outputs.
- FRAME_BASE_ADDR, 32'h0100_0000, DDR address of slot 0.
- FRAME_STRIDE, 32'h0020_0000, byte distance between slots; must be at least the frame size.

Ports:
- clk_100Mhz  input  1  system/AXI clock.
- rst  input  1  asynchronous, active-high reset.
- wr_frame_done  input  1  single-cycle pulse: writer has finished a frame (already synchronised to clk_100Mhz).
- wr_burst_active  input  1  high while the writer has an AXI burst outstanding (from AW handshake until B response).
- rd_frame_start  input  1  single-cycle pulse: reader is starting a new frame (vsync).
- wr_base_addr  output  AXI_ADDR_WIDTH  base address of the writer's current slot.
- wr_buf_idx  output  2  index of the writer's slot.
- rd_base_addr  output  AXI_ADDR_WIDTH  base address of the reader's current slot.
- rd_buf_idx  output  2  index of the reader's slot.
- rd_new_frame  output  1  one-cycle pulse: the reader received a fresh slot.
- swap_pending  output  1  a writer commit is deferred until the current burst ends.
- drop_count  output  16  frames overwritten before the reader took them.
- repeat_count  output  16  reader frame starts with no new frame available.

Behaviour:
- Internal state:
  - w_idx: writer slot.
  - r_idx: reader slot.
  - t_idx: third slot.
  - ready_valid: t_idx holds a completed frame not yet taken by the reader.
  - w_idx, r_idx and t_idx are always distinct values in {0,1,2}; index 3 is never produced.
- Reset values:
  - w_idx=0, r_idx=2, t_idx=1, ready_valid=0.
  - wr_base_addr=FRAME_BASE_ADDR.
  - rd_base_addr=FRAME_BASE_ADDR+2*FRAME_STRIDE.
  - rd_new_frame=0, swap_pending=0, both counts=0.
- Writer FSM states: IDLE, DEFER, COMMIT.
  - IDLE → COMMIT on wr_frame_done when wr_burst_active=0.
  - IDLE → DEFER on wr_frame_done when wr_burst_active=1. swap_pending=1 while in DEFER.
  - DEFER → COMMIT on the first cycle with wr_burst_active=0.
  - A further wr_frame_done while in DEFER or COMMIT is absorbed (no second commit).
  - COMMIT lasts 1 cycle, then returns to IDLE.
- Commit action (in COMMIT):
  - t_idx←w_idx, w_idx←old t_idx, ready_valid←1.
  - If ready_valid was already 1, drop_count increments.
- Reader action on rd_frame_start:
  - If ready_valid=1: r_idx←t_idx, t_idx←old r_idx, ready_valid←0, rd_new_frame pulses the next cycle.
  - Otherwise: no swap and repeat_count increments.
- Simultaneous COMMIT and rd_frame_start: the commit is applied first, then the read swap.
  - Starting from (w=a, r=b, t=c), the result is w=c, r=a, t=b, ready_valid=0.
  - drop_count follows the commit rule above.
- Address outputs:
  - Registered. Each equals FRAME_BASE_ADDR + idx*FRAME_STRIDE, computed at AXI_ADDR_WIDTH with modulo wrap.
  - Outputs update 1 cycle after the index changes, i.e. 2 cycles after wr_frame_done with no burst active.
  - wr_base_addr never changes while wr_burst_active=1.
- Counters saturate at 16'hFFFF.
- Reset asserted mid-operation returns everything to reset values immediately, including any deferred commit, which is lost.

Optional Feature:
- Macro FB_STATS_EN.
- When defined: drop_count and repeat_count behave as described.
- When undefined: both outputs are constant 0 and the counter registers are not synthesised. Buffer scheduling is identical either way.

Test Plan:
- Reset, then one wr_frame_done with burst idle → wr_buf_idx 0→1, wr_base_addr=32'h0120_0000 after 2 cycles. Next rd_frame_start → rd_buf_idx=0, rd_base_addr=32'h0100_0000, rd_new_frame pulses once.
- wr_frame_done while wr_burst_active=1 for 10 more cycles → swap_pending=1 and wr_base_addr unchanged throughout. Commit happens the cycle after burst_active falls.
- Three wr_frame_done pulses with no reads → drop_count=2, reader slot stays 2, writer slot never equals 2.
- rd_frame_start with ready_valid=0 → no rd_new_frame, rd_base_addr unchanged, repeat_count=1.
- wr_frame_done (no burst) landing in the same cycle as rd_frame_start, from w=1,r=2,t=0 with ready_valid=1 → final w=0,r=1,t=2, drop_count=1.
- rst asserted during DEFER → outputs return to reset values and the deferred commit is not performed after release. Compile without FB_STATS_EN → both counts read 0.

Source files
------------

// File: rtl/frame_buffer_scheduler_if.sv
// rtl/frame_buffer_scheduler_if.sv - Writer/reader control inputs and slot outputs of the frame buffer scheduler
interface frame_buffer_scheduler_if #(
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                      wr_frame_done;
    logic                      wr_burst_active;
    logic                      rd_frame_start;
    logic [AXI_ADDR_WIDTH-1:0] wr_base_addr;
    logic [1:0]                wr_buf_idx;
    logic [AXI_ADDR_WIDTH-1:0] rd_base_addr;
    logic [1:0]                rd_buf_idx;
    logic                      rd_new_frame;
    logic                      swap_pending;
    logic [15:0]               drop_count;
    logic [15:0]               repeat_count;

    modport master (
        output wr_frame_done, wr_burst_active, rd_frame_start,
        input  wr_base_addr, wr_buf_idx, rd_base_addr, rd_buf_idx,
               rd_new_frame, swap_pending, drop_count, repeat_count
    );

    modport slave (
        input  wr_frame_done, wr_burst_active, rd_frame_start,
        output wr_base_addr, wr_buf_idx, rd_base_addr, rd_buf_idx,
               rd_new_frame, swap_pending, drop_count, repeat_count
    );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// rtl/frame_buffer_scheduler.sv - Triple-buffer slot scheduler for DDR frame store writer and HDMI reader
// Optional drop/repeat statistics counters enabled by defining FB_STATS_EN.
module frame_buffer_scheduler #(
    parameter int          AXI_ADDR_WIDTH  = 32,
    parameter logic [31:0] FRAME_BASE_ADDR = 32'h0100_0000,
    parameter logic [31:0] FRAME_STRIDE    = 32'h0020_0000
) (
    input logic                   clk_100Mhz,
    input logic                   rst,
    frame_buffer_scheduler_if.slave bus
);
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE   = AXI_ADDR_WIDTH'(FRAME_BASE_ADDR);
    localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(FRAME_STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_DEFER, S_COMMIT} wr_state_t;

    wr_state_t                 state_q, state_d;
    logic [1:0]                w_q, w_d, r_q, r_d, t_q, t_d;
    logic                      rv_q, rv_d;
    logic                      new_q, new_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;

    function automatic logic [AXI_ADDR_WIDTH-1:0] slot_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return BASE;
            2'd1:    return BASE + STRIDE;
            default: return BASE + STRIDE + STRIDE;
        endcase
    endfunction

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            w_q       <= 2'd0;
            r_q       <= 2'd2;
            t_q       <= 2'd1;
            rv_q      <= 1'b0;
            new_q     <= 1'b0;
            wr_addr_q <= BASE;
            rd_addr_q <= BASE + STRIDE + STRIDE;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            r_q       <= r_d;
            t_q       <= t_d;
            rv_q      <= rv_d;
            new_q     <= new_d;
            wr_addr_q <= slot_addr(w_q);
            rd_addr_q <= slot_addr(r_q);
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        r_d     = r_q;
        t_d     = t_q;
        rv_d    = rv_q;
        new_d   = 1'b0;
        case (state_q)
            S_IDLE:   if (bus.wr_frame_done) state_d = bus.wr_burst_active ? S_DEFER : S_COMMIT;
            S_DEFER:  if (!bus.wr_burst_active) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Commit is applied before a coincident read so the reader gets the frame just finished.
        if (state_q == S_COMMIT) begin
            w_d  = t_q;
            t_d  = w_q;
            rv_d = 1'b1;
        end
        if (bus.rd_frame_start && rv_d) begin
            r_d   = t_d;
            t_d   = r_q;
            rv_d  = 1'b0;
            new_d = 1'b1;
        end
    end

    assign bus.wr_base_addr = wr_addr_q;
    assign bus.rd_base_addr = rd_addr_q;
    assign bus.wr_buf_idx   = w_q;
    assign bus.rd_buf_idx   = r_q;
    assign bus.rd_new_frame = new_q;
    assign bus.swap_pending = (state_q == S_DEFER);

`ifdef FB_STATS_EN
    logic [15:0] drop_q, rep_q;

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            drop_q <= 16'd0;
            rep_q  <= 16'd0;
        end else begin
            if (state_q == S_COMMIT && rv_q && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
            if (bus.rd_frame_start && !rv_q && state_q != S_COMMIT && rep_q != 16'hFFFF)
                rep_q <= rep_q + 16'd1;
        end
    end

    assign bus.drop_count   = drop_q;
    assign bus.repeat_count = rep_q;
`else
    assign bus.drop_count   = 16'd0;
    assign bus.repeat_count = 16'd0;
`endif
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb/tb_frame_buffer_scheduler.sv - Randomized self-checking bench for frame_buffer_scheduler
`timescale 1ns/1ps
module tb_frame_buffer_scheduler;
`ifdef FB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_buffer_scheduler_if #(.AXI_ADDR_WIDTH(32)) bus ();

    frame_buffer_scheduler #(
        .AXI_ADDR_WIDTH (32),
        .FRAME_BASE_ADDR(32'h0100_0000),
        .FRAME_STRIDE   (32'h0020_0000)
    ) dut (
        .clk_100Mhz(clk),
        .rst       (rst),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: three slots with roles, a pending-commit record and counts.
    int mw, mr, mt;
    bit mready, mdefer, mcommit, mnew;
    int mwa, mra;
    int mdrop, mrep;

    function automatic logic [31:0] addr_of(input int idx);
        return 32'h0100_0000 + idx * 32'h0020_0000;
    endfunction

    function automatic int sat(input int x);
        return (x < 65535) ? x + 1 : x;
    endfunction

    task automatic model_reset();
        mw = 0; mr = 2; mt = 1;
        mready = 0; mdefer = 0; mcommit = 0; mnew = 0;
        mwa = 0; mra = 2;
        mdrop = 0; mrep = 0;
    endtask

    task automatic model_update(input bit done, input bit burst, input bit rd, input bit rs);
        bit committing;
        int tmp;
        if (rs) begin
            model_reset();
            return;
        end
        committing = mcommit;
        mwa = mw;
        mra = mr;
        if (committing) begin
            if (mready) mdrop = sat(mdrop);
            tmp = mw; mw = mt; mt = tmp;
            mready = 1;
        end
        mnew = 0;
        if (rd) begin
            if (mready) begin
                tmp = mr; mr = mt; mt = tmp;
                mready = 0;
                mnew = 1;
            end else begin
                mrep = sat(mrep);
            end
        end
        if (committing) mcommit = 0;
        else if (mdefer) begin
            if (!burst) begin mdefer = 0; mcommit = 1; end
        end else if (done) begin
            if (burst) mdefer = 1; else mcommit = 1;
        end
    endtask

    task automatic compare_all();
        chk("w_idx",  {30'd0, bus.wr_buf_idx}, mw);
        chk("r_idx",  {30'd0, bus.rd_buf_idx}, mr);
        chk("w_addr", bus.wr_base_addr, addr_of(mwa));
        chk("r_addr", bus.rd_base_addr, addr_of(mra));
        chk("r_new",  {31'd0, bus.rd_new_frame}, mnew);
        chk("pend",   {31'd0, bus.swap_pending}, mdefer);
        chk("drop",   {16'd0, bus.drop_count},   STATS ? mdrop : 0);
        chk("repeat", {16'd0, bus.repeat_count}, STATS ? mrep : 0);
    endtask

    // Called at a negedge: drive, let one rising edge pass, check at the next negedge.
    task automatic step(input bit done, input bit burst, input bit rd, input bit rs);
        rst = rs;
        bus.wr_frame_done   = done;
        bus.wr_burst_active = burst;
        bus.rd_frame_start  = rd;
        @(posedge clk);
        model_update(done, burst, rd, rs);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit burst;
        rst = 1'b1;
        bus.wr_frame_done   = 1'b0;
        bus.wr_burst_active = 1'b0;
        bus.rd_frame_start  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_waddr", bus.wr_base_addr, 32'h0100_0000);
        chk("rst_raddr", bus.rd_base_addr, 32'h0140_0000);

        // Read with nothing ready: repeat, no swap
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("rep_new",   {31'd0, bus.rd_new_frame}, 0);
        chk("rep_raddr", bus.rd_base_addr, 32'h0140_0000);
        chk("rep_count", {16'd0, bus.repeat_count}, STATS ? 1 : 0);

        // First frame with burst idle, then a read takes it
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("tp1_widx", {30'd0, bus.wr_buf_idx}, 1);
        step(0, 0, 0, 0);
        chk("tp1_waddr", bus.wr_base_addr, 32'h0120_0000);
        step(0, 0, 1, 0);
        chk("tp1_rnew", {31'd0, bus.rd_new_frame}, 1);
        chk("tp1_ridx", {30'd0, bus.rd_buf_idx}, 0);
        step(0, 0, 0, 0);
        chk("tp1_raddr", bus.rd_base_addr, 32'h0100_0000);
        chk("tp1_rnew2", {31'd0, bus.rd_new_frame}, 0);

        // Frame done during a burst: deferred until the burst ends
        step(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0);
            chk("tp2_waddr", bus.wr_base_addr, 32'h0120_0000);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("tp2_widx", {30'd0, bus.wr_buf_idx}, 2);
        step(0, 0, 0, 0);

        // Three frames with no reads
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            repeat (3) step(0, 0, 0, 0);
            chk("tp3_wnot2", {31'd0, bus.wr_buf_idx == 2'd2}, 0);
        end
        chk("tp3_ridx", {30'd0, bus.rd_buf_idx}, 2);
        chk("tp3_drop", {16'd0, bus.drop_count}, STATS ? 2 : 0);

        // Commit coinciding with a read, from w=1 r=2 t=0 ready
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("tp5_widx", {30'd0, bus.wr_buf_idx}, 0);
        chk("tp5_ridx", {30'd0, bus.rd_buf_idx}, 1);
        chk("tp5_drop", {16'd0, bus.drop_count}, STATS ? 1 : 0);

        // Reset asserted mid-deferral: the commit is lost
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("tp6_pend", {31'd0, bus.swap_pending}, 1);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("tp6_rst_pend", {31'd0, bus.swap_pending}, 0);
        @(negedge clk);
        step(0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("tp6_widx", {30'd0, bus.wr_buf_idx}, 0);
        chk("tp6_waddr", bus.wr_base_addr, 32'h0100_0000);

        // Randomized traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) burst = ~burst;
            step($urandom_range(0, 11) == 0, burst, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 599) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
